coherence_arbiter: RTL and testbench

- Controller side of the cache control bus (the cc modport) for a dual-core system.
- Shares one single-word RAM port between 2 icaches and 2 dcaches using fixed type priority plus per-class round-robin.
- Sequences MSI snoops: a dcache miss marked cctrans snoops the peer dcache.
- When the peer holds a dirty copy, performs a cache-to-cache transfer with simultaneous RAM writeback.

---
 rtl/coherence_arbiter_if.sv | 28 ++
 rtl/coherence_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_coherence_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/coherence_arbiter_if.sv
// Cache control bus shared by the coherence arbiter (cc side) and the caches/RAM (caches side).
// Also carries the package holding the RAM handshake state type.
package coherence_arbiter_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef logic [31:0] word_t;
endpackage

interface coherence_arbiter_if #(parameter int unsigned CPUS = 2);
    import coherence_arbiter_pkg::*;

    logic [CPUS-1:0]  iwait, dwait, iREN, dREN, dWEN;
    word_t [CPUS-1:0] iload, dload, dstore, iaddr, daddr;
    logic [CPUS-1:0]  ccwait, ccinv, ccwrite, cctrans;
    word_t [CPUS-1:0] ccsnoopaddr;
    logic             ramWEN, ramREN;
    ramstate_t        ramstate;
    word_t            ramaddr, ramload, ramstore;

    modport cc (
        input  iREN, dREN, dWEN, dstore, iaddr, daddr, ccwrite, cctrans, ramstate, ramload,
        output iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr, ramWEN, ramREN, ramaddr, ramstore
    );

    modport caches (
        output iREN, dREN, dWEN, dstore, iaddr, daddr, ccwrite, cctrans, ramstate, ramload,
        input  iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr, ramWEN, ramREN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_arbiter.sv
// Dual-core coherence arbiter: shares one RAM port among 2 icaches and 2 dcaches, sequences MSI snoops
// and cache-to-cache transfers. Optional macro CC_STATS_EN adds saturating snoop/C2C/timeout counters.
module coherence_arbiter
    import coherence_arbiter_pkg::*;
#(
    parameter int unsigned CPUS          = 2,
    parameter int unsigned SNOOP_TIMEOUT = 4,
    parameter logic        RR_INIT       = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    coherence_arbiter_if.cc   ccif
`ifdef CC_STATS_EN
    ,
    output logic [15:0]       snoop_count,
    output logic [15:0]       c2c_count,
    output logic [15:0]       timeout_count
`endif
);
    typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, RAMRD, IFETCH} state_t;

    state_t     state;
    logic       g, drr, irr, snooped;
    logic [3:0] cnt;
    logic       o;

    assign o = ~g;

    function automatic logic pick(input logic [1:0] req, input logic ptr);
        return (&req) ? ptr : ~req[0];
    endfunction

    logic gw, gr, gi, done, go_snoop, hit, clean, expire;

    assign gw       = pick(ccif.dWEN, drr);
    assign gr       = pick(ccif.dREN, drr);
    assign gi       = pick(ccif.iREN, irr);
    // A reset cycle must never show a completion pulse even though the state is still live.
    assign done     = (ccif.ramstate == ACCESS) && !RST;
    assign go_snoop = (state == IDLE) && !(|ccif.dWEN) && (|ccif.dREN) && ccif.cctrans[gr];
    assign hit      = (state == SNOOP) && ccif.dWEN[o] && (ccif.daddr[o] == ccif.daddr[g]);
    assign clean    = (state == SNOOP) && !hit && ccif.cctrans[o] && !ccif.dWEN[o];
    assign expire   = (state == SNOOP) && !hit && !clean && (cnt == 4'(SNOOP_TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            g       <= 1'b0;
            drr     <= RR_INIT;
            irr     <= RR_INIT;
            cnt     <= '0;
            snooped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    snooped <= 1'b0;
                    if (|ccif.dWEN) begin
                        g     <= gw;
                        state <= WB;
                    end else if (|ccif.dREN) begin
                        g     <= gr;
                        state <= go_snoop ? SNOOP : RAMRD;
                    end else if (|ccif.iREN) begin
                        g     <= gi;
                        state <= IFETCH;
                    end
                end
                SNOOP: begin
                    if (hit) begin
                        state <= C2C;
                        cnt   <= '0;
                    end else if (clean || expire) begin
                        state   <= RAMRD;
                        snooped <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WB, C2C, RAMRD: begin
                    if (done) begin
                        drr   <= ~g;
                        state <= IDLE;
                    end
                end
                IFETCH: begin
                    if (done) begin
                        irr   <= ~g;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [CPUS-1:0]  iwait_c, dwait_c, ccwait_c, ccinv_c;
    word_t [CPUS-1:0] iload_c, dload_c, snoop_c;
    logic             ren_c, wen_c;
    word_t            addr_c, store_c;

    always_comb begin
        iwait_c  = '1;
        dwait_c  = '1;
        ccwait_c = '0;
        ccinv_c  = '0;
        snoop_c  = '0;
        iload_c  = '0;
        dload_c  = '0;
        ren_c    = 1'b0;
        wen_c    = 1'b0;
        addr_c   = '0;
        store_c  = '0;
        case (state)
            WB: begin
                wen_c   = 1'b1;
                addr_c  = ccif.daddr[g];
                store_c = ccif.dstore[g];
                if (done) dwait_c[g] = 1'b0;
            end
            SNOOP: begin
                ccwait_c[o] = 1'b1;
                snoop_c[o]  = ccif.daddr[g];
                ccinv_c[o]  = ccif.ccwrite[g];
            end
            C2C: begin
                ccwait_c[o] = 1'b1;
                wen_c       = 1'b1;
                addr_c      = ccif.daddr[o];
                store_c     = ccif.dstore[o];
                dload_c[g]  = ccif.dstore[o];
                if (done) begin
                    dwait_c[g] = 1'b0;
                    dwait_c[o] = 1'b0;
                end
            end
            RAMRD: begin
                if (snooped) begin
                    ccwait_c[o] = 1'b1;
                    ccinv_c[o]  = ccif.ccwrite[g];
                end
                ren_c      = 1'b1;
                addr_c     = ccif.daddr[g];
                dload_c[g] = ccif.ramload;
                if (done) dwait_c[g] = 1'b0;
            end
            IFETCH: begin
                ren_c      = 1'b1;
                addr_c     = ccif.iaddr[g];
                iload_c[g] = ccif.ramload;
                if (done) iwait_c[g] = 1'b0;
            end
            default: ;
        endcase
    end

    assign ccif.iwait       = iwait_c;
    assign ccif.dwait       = dwait_c;
    assign ccif.iload       = iload_c;
    assign ccif.dload       = dload_c;
    assign ccif.ccwait      = ccwait_c;
    assign ccif.ccinv       = ccinv_c;
    assign ccif.ccsnoopaddr = snoop_c;
    assign ccif.ramREN      = ren_c;
    assign ccif.ramWEN      = wen_c;
    assign ccif.ramaddr     = addr_c;
    assign ccif.ramstore    = store_c;

`ifdef CC_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            snoop_count   <= '0;
            c2c_count     <= '0;
            timeout_count <= '0;
        end else begin
            if (go_snoop && snoop_count != '1)   snoop_count   <= snoop_count + 16'd1;
            if (hit && c2c_count != '1)          c2c_count     <= c2c_count + 16'd1;
            if (expire && timeout_count != '1)   timeout_count <= timeout_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_coherence_arbiter.sv
// Directed bench for coherence_arbiter: a per-cycle vector table plus a hand-written reset-abort sequence.
module tb_coherence_arbiter;
    import coherence_arbiter_pkg::*;

    logic CLK, RST;
    int   ncmp, nfail;

    coherence_arbiter_if #(.CPUS(2)) bus ();

`ifdef CC_STATS_EN
    logic [15:0] snoop_count, c2c_count, timeout_count;
`endif

    coherence_arbiter #(.CPUS(2), .SNOOP_TIMEOUT(4), .RR_INIT(1'b0)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .ccif          (bus.cc)
`ifdef CC_STATS_EN
        ,
        .snoop_count   (snoop_count),
        .c2c_count     (c2c_count),
        .timeout_count (timeout_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  iren, dren, dwen, ctr, cwr;
        ramstate_t   rs;
        logic [31:0] rl;
        logic [63:0] da, ds;
        logic [1:0]  e_iw, e_dw, e_cw, e_ci;
        logic        e_rr, e_rw;
        logic [31:0] e_ra, e_rs;
        logic [63:0] e_il, e_dl, e_sn;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] iren, dren, dwen, ctr, cwr, input ramstate_t rs,
                         input logic [31:0] rl, input logic [63:0] da, ds);
        bus.iREN     = iren;
        bus.dREN     = dren;
        bus.dWEN     = dwen;
        bus.cctrans  = ctr;
        bus.ccwrite  = cwr;
        bus.ramstate = rs;
        bus.ramload  = rl;
        bus.daddr    = da;
        bus.dstore   = ds;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".iwait"},  bus.iwait,       64'h3);
        chk({tag, ".dwait"},  bus.dwait,       64'h3);
        chk({tag, ".ccwait"}, bus.ccwait,      64'h0);
        chk({tag, ".ccinv"},  bus.ccinv,       64'h0);
        chk({tag, ".snoop"},  bus.ccsnoopaddr, 64'h0);
        chk({tag, ".ramREN"}, bus.ramREN,      64'h0);
        chk({tag, ".ramWEN"}, bus.ramWEN,      64'h0);
        chk({tag, ".raddr"},  bus.ramaddr,     64'h0);
        chk({tag, ".rstore"}, bus.ramstore,    64'h0);
        chk({tag, ".iload"},  bus.iload,       64'h0);
        chk({tag, ".dload"},  bus.dload,       64'h0);
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        //          iren   dren   dwen   ctr    cwr    rs      rl            da                      ds                      iw     dw     cw     ci     rr    rw    ra          rs            il                      dl                      sn
        vecs = '{
            '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0,        64'h0,                  64'h0,                  2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, BUSY,   32'h11110000, 64'h0,                  64'h0,                  2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100,    32'h0,        64'h0000_0000_1111_0000, 64'h0,                 64'h0},
            '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, ERROR,  32'h22220000, 64'h0,                  64'h0,                  2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100,    32'h0,        64'h0000_0000_2222_0000, 64'h0,                 64'h0},
            '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, ACCESS, 32'hCAFE0100, 64'h0,                  64'h0,                  2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100,    32'h0,        64'h0000_0000_CAFE_0100, 64'h0,                 64'h0},
            '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0,        64'h0,                  64'h0,                  2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, ACCESS, 32'hCAFE0200, 64'h0,                  64'h0,                  2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h200,    32'h0,        64'hCAFE_0200_0000_0000, 64'h0,                 64'h0},
            '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0,        64'h0,                  64'h0,                  2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, ACCESS, 32'h77,       64'h0,                  64'h0,                  2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100,    32'h0,        64'h0000_0000_0000_0077, 64'h0,                 64'h0},
            '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, FREE,   32'h0,        64'h0000_0000_0000_0040, 64'h0000_0000_DEAD_BEEF, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, BUSY,   32'h0,        64'h0000_0000_0000_0040, 64'h0000_0000_DEAD_BEEF, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 32'h40,     32'hDEADBEEF, 64'h0,                  64'h0,                  64'h0},
            '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, ACCESS, 32'h0,        64'h0000_0000_0000_0040, 64'h0000_0000_DEAD_BEEF, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 32'h40,     32'hDEADBEEF, 64'h0,                  64'h0,                  64'h0},
            '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0,        64'h0,                  64'h0,                  2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, ACCESS, 32'h5555,     64'h0,                  64'h0,                  2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h200,    32'h0,        64'h0000_5555_0000_0000, 64'h0,                 64'h0},
            '{2'b00, 2'b01, 2'b00, 2'b01, 2'b01, FREE,   32'h0,        64'h0000_0000_0000_0080, 64'h0,                 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b00, 2'b01, 2'b10, 2'b01, 2'b01, FREE,   32'h0,        64'h0000_0080_0000_0080, 64'h1234_5678_0000_0000, 2'b11, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0000_0080_0000_0000},
            '{2'b00, 2'b01, 2'b10, 2'b01, 2'b01, BUSY,   32'h0,        64'h0000_0080_0000_0080, 64'h1234_5678_0000_0000, 2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 1'b1, 32'h80,     32'h12345678, 64'h0,                  64'h0000_0000_1234_5678, 64'h0},
            '{2'b00, 2'b01, 2'b10, 2'b01, 2'b01, ACCESS, 32'h0,        64'h0000_0080_0000_0080, 64'h1234_5678_0000_0000, 2'b11, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 32'h80,     32'h12345678, 64'h0,                  64'h0000_0000_1234_5678, 64'h0},
            '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, FREE,   32'h0,        64'h0000_00C0_0000_0000, 64'h0,                 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00, FREE,   32'h0,        64'h0000_00C0_0000_0000, 64'h0,                 2'b11, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0000_0000_0000_00C0},
            '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00, BUSY,   32'hC0C0,     64'h0000_00C0_0000_0000, 64'h0,                 2'b11, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 32'hC0,     32'h0,        64'h0,                  64'h0000_C0C0_0000_0000, 64'h0},
            '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00, ACCESS, 32'hBEEF00C0, 64'h0000_00C0_0000_0000, 64'h0,                 2'b11, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'hC0,     32'h0,        64'h0,                  64'hBEEF_00C0_0000_0000, 64'h0},
            '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0,        64'h0,                  64'h0,                  2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, FREE,   32'h0,        64'h0000_0000_0000_0080, 64'h0,                 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, FREE,   32'h0,        64'h0000_0000_0000_0080, 64'h0,                 2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0000_0080_0000_0000},
            '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, FREE,   32'h0,        64'h0000_0000_0000_0080, 64'h0,                 2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0000_0080_0000_0000},
            '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, FREE,   32'h0,        64'h0000_0000_0000_0080, 64'h0,                 2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0000_0080_0000_0000},
            '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, FREE,   32'h0,        64'h0000_0000_0000_0080, 64'h0,                 2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0000_0080_0000_0000},
            '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, ACCESS, 32'h99,       64'h0000_0000_0000_0080, 64'h0,                 2'b11, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 32'h80,     32'h0,        64'h0,                  64'h0000_0000_0000_0099, 64'h0},
            '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0,        64'h0,                  64'h0,                  2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, FREE,   32'h0,        64'h0000_0104_0000_0108, 64'h0,                 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, ACCESS, 32'h31,       64'h0000_0104_0000_0108, 64'h0,                 2'b11, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 32'h104,    32'h0,        64'h0,                  64'h0000_0031_0000_0000, 64'h0},
            '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, FREE,   32'h0,        64'h0000_0104_0000_0108, 64'h0,                 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0},
            '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, ACCESS, 32'h32,       64'h0000_0104_0000_0108, 64'h0,                 2'b11, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 32'h108,    32'h0,        64'h0,                  64'h0000_0000_0000_0032, 64'h0},
            '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, FREE,   32'h0,        64'h0,                  64'h0,                  2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0}
        };

        RST       = 1'b1;
        bus.iaddr = {32'h200, 32'h100};
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, FREE, 32'h0, 64'h0, 64'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].ctr, vecs[i].cwr,
                  vecs[i].rs, vecs[i].rl, vecs[i].da, vecs[i].ds);
            @(negedge CLK);
            chk($sformatf("r%0d.iwait", i),  bus.iwait,       vecs[i].e_iw);
            chk($sformatf("r%0d.dwait", i),  bus.dwait,       vecs[i].e_dw);
            chk($sformatf("r%0d.ccwait", i), bus.ccwait,      vecs[i].e_cw);
            chk($sformatf("r%0d.ccinv", i),  bus.ccinv,       vecs[i].e_ci);
            chk($sformatf("r%0d.ramREN", i), bus.ramREN,      vecs[i].e_rr);
            chk($sformatf("r%0d.ramWEN", i), bus.ramWEN,      vecs[i].e_rw);
            chk($sformatf("r%0d.raddr", i),  bus.ramaddr,     vecs[i].e_ra);
            chk($sformatf("r%0d.rstore", i), bus.ramstore,    vecs[i].e_rs);
            chk($sformatf("r%0d.iload", i),  bus.iload,       vecs[i].e_il);
            chk($sformatf("r%0d.dload", i),  bus.dload,       vecs[i].e_dl);
            chk($sformatf("r%0d.snoop", i),  bus.ccsnoopaddr, vecs[i].e_sn);
            tick();
        end

`ifdef CC_STATS_EN
        chk("stats.snoop",   snoop_count,   64'd3);
        chk("stats.c2c",     c2c_count,     64'd1);
        chk("stats.timeout", timeout_count, 64'd1);
`endif

        // Reset landing on the C2C completion cycle: no pulse, then clean IDLE with drr back at 0.
        drive(2'b00, 2'b01, 2'b00, 2'b01, 2'b00, FREE, 32'h0, 64'h0000_0080_0000_0080, 64'h0000_ABCD_0000_0000);
        tick();
        bus.dWEN = 2'b10;
        tick();
        bus.ramstate = ACCESS;
        RST          = 1'b1;
        @(negedge CLK);
        chk("rst_c2c.dwait", bus.dwait, 64'h3);
        tick();
        RST = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, FREE, 32'h0, 64'h0, 64'h0);
        @(negedge CLK);
        chk_idle("post_rst");
`ifdef CC_STATS_EN
        chk("post_rst.snoop_count", snoop_count, 64'd0);
        chk("post_rst.c2c_count",   c2c_count,   64'd0);
`endif
        tick();
        drive(2'b00, 2'b11, 2'b00, 2'b00, 2'b00, FREE, 32'h0, 64'h0000_0300_0000_0400, 64'h0);
        @(negedge CLK);
        chk("drr_rst.idle_dwait", bus.dwait, 64'h3);
        tick();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h44;
        @(negedge CLK);
        chk("drr_rst.raddr", bus.ramaddr, 64'h400);
        chk("drr_rst.dwait", bus.dwait,   64'h2);
        chk("drr_rst.dload", bus.dload,   64'h0000_0000_0000_0044);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
